// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared constants for the instruction prefetch buffer and its FIFO.
package instr_prefetch_buffer_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous FIFO with clear; depth need not be a power of two so the
// same block serves as the instruction buffer and the in-order PC tag queue.
module instr_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word fetches ahead of the core,
// buffers {pc, instr} pairs and flushes/restarts on execute-stage redirects.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_bus_req,
  output logic [ADDR_W-1:0] o_bus_addr,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [WIDTH-1:0]  i_bus_rdata,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_instr,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic                    run_q;
  logic [ADDR_W-1:0]       fpc_q, fpc_d;
  logic [OW-1:0]           discard_q, discard_d;

  logic [ADDR_W+WIDTH-1:0] buf_rdata;
  logic                    buf_full, buf_empty, buf_push, buf_pop;
  logic [CW-1:0]           buf_count;

  logic [ADDR_W-1:0]       tag_pc;
  logic                    tag_full, tag_empty, tag_pop;
  logic [OW-1:0]           outst;
  logic                    bus_hs;

  // Request depends only on registered state, so it cannot glitch off while
  // waiting for a grant: responses move slots from outst to count, never freeing any.
  assign o_bus_req  = run_q & ~tag_full & ((32'(buf_count) + 32'(outst)) < DEPTH);
  assign o_bus_addr = fpc_q;
  assign bus_hs     = o_bus_req & i_bus_gnt;

  assign tag_pop  = i_bus_rvalid & ~tag_empty;
  assign buf_push = i_bus_rvalid & ~i_redirect & (discard_q == '0);
  assign buf_pop  = o_valid & i_ready & ~i_redirect;

  assign o_valid = ~buf_empty;
  assign o_instr = buf_empty ? WIDTH'(NOP_INSTR) : buf_rdata[WIDTH-1:0];
  assign o_pc    = buf_empty ? fpc_q : buf_rdata[ADDR_W+WIDTH-1:WIDTH];

  instr_fifo #(.DW(ADDR_W + WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (i_redirect),
    .push_i  (buf_push),
    .data_i  ({tag_pc, i_bus_rdata}),
    .pop_i   (buf_pop),
    .data_o  (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  instr_fifo #(.DW(ADDR_W), .DEPTH(MAX_OUTST)) u_tags (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (1'b0),
    .push_i  (bus_hs),
    .data_i  (fpc_q),
    .pop_i   (tag_pop),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outst)
  );

  always_comb begin
    fpc_d     = fpc_q;
    discard_d = discard_q;
    if (i_redirect) begin
      fpc_d     = {i_redirect_pc[ADDR_W-1:2], 2'b00};
      // Everything still in flight after this edge belongs to the old path.
      discard_d = outst + OW'(bus_hs) - OW'(tag_pop);
    end else begin
      if (bus_hs) fpc_d = fpc_q + ADDR_W'(PC_INC);
      if (i_bus_rvalid && discard_q != '0) discard_d = discard_q - OW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_q     <= 1'b0;
      fpc_q     <= RESET_PC;
      discard_q <= '0;
    end else begin
      run_q     <= 1'b1;
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
    end
  end

  // buf_full only matters inside the FIFO's own push guard.
  logic unused_full;
  assign unused_full = buf_full;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomised and directed checks of the prefetch buffer against a queue-based
// model of the bus and of the instruction stream the core should see.
module tb_instr_prefetch_buffer;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_prefetch_buffer #(
    .WIDTH(32), .ADDR_W(32), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .i_bus_gnt(i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; int ep; } txn_t;
  txn_t        pend[$];
  logic [31:0] exp_q[$];
  int          epoch = 0;
  int          cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int          pass_cnt = 0, total = 0;
  logic [31:0] next_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One bus/core cycle: memory answers in order, model tracks what the core should see.
  task automatic tick(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit   rv, hs, pop;
    txn_t t;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    i_bus_rvalid  = rv;
    i_bus_rdata   = rv ? memf(pend[0].addr) : $urandom;
    i_bus_gnt     = gnt;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    hs  = (o_bus_req === 1'b1) && gnt;
    pop = (o_valid === 1'b1) && rdy && !redir;
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (rv) begin
      t = pend.pop_front();
      if (!redir && t.ep == epoch) exp_q.push_back(t.addr);
    end
    if (hs) begin
      t.addr = o_bus_addr;
      t.due  = cyc + int'($urandom_range(lat_max, lat_min));
      t.ep   = epoch;
      pend.push_back(t);
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) tick(0, 0, 0, '0);
    total++; if (o_bus_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", o_bus_req); else pass_cnt++;
    total++; if (o_bus_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", o_bus_addr); else pass_cnt++;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else pass_cnt++;
    total++; if (o_instr !== NOP) $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP); else pass_cnt++;
    total++; if (o_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", o_pc); else pass_cnt++;
  endtask

  task automatic test_stream();
    i_rst = 1'b0;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        total++; if (o_bus_req !== 1'b0) $display("FAIL stream_req0 got=%b exp=0", o_bus_req); else pass_cnt++;
      end else begin
        total++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== 32'(4 * (k - 1)))
          $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, o_bus_req, o_bus_addr, 32'(4 * (k - 1)));
        else pass_cnt++;
      end
      total++;
      if (o_valid !== (k >= 3)) $display("FAIL stream_valid k=%0d got=%b exp=%b", k, o_valid, k >= 3);
      else pass_cnt++;
      if (k >= 3) begin
        total++;
        if (o_pc !== 32'(4 * (k - 3)) || o_instr !== memf(32'(4 * (k - 3))))
          $display("FAIL stream_pc k=%0d got=%h/%h exp=%h/%h", k, o_pc, o_instr, 32'(4 * (k - 3)), memf(32'(4 * (k - 3))));
        else pass_cnt++;
      end
      tick(1, 1, 0, '0);
    end
    next_pc = 32'd24;
  endtask

  task automatic test_stall();
    int consumed = 0;
    repeat (10) tick(1, 0, 0, '0);
    total++; if (o_bus_req !== 1'b0) $display("FAIL stall_req got=%b exp=0", o_bus_req); else pass_cnt++;
    total++; if (exp_q.size() != 4) $display("FAIL stall_buffered got=%0d exp=4", exp_q.size()); else pass_cnt++;
    total++;
    if (o_valid !== 1'b1 || o_pc !== next_pc) $display("FAIL stall_head got=%b/%h exp=1/%h", o_valid, o_pc, next_pc);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      if (o_valid === 1'b1) begin
        total++;
        if (o_pc !== next_pc || o_instr !== memf(next_pc))
          $display("FAIL release_pc got=%h/%h exp=%h/%h", o_pc, o_instr, next_pc, memf(next_pc));
        else pass_cnt++;
        next_pc += 4;
        consumed++;
      end
      tick(1, 1, 0, '0);
    end
    total++; if (consumed != 12) $display("FAIL release_throughput got=%0d exp=12", consumed); else pass_cnt++;
  endtask

  task automatic test_redirect_fast();
    total++;
    if (o_bus_req !== 1'b1 || pend.size() == 0)
      $display("FAIL redir_pre got=%b/%0d exp=1/>0", o_bus_req, pend.size());
    else pass_cnt++;
    tick(1, 1, 1, 32'h0000_0203);
    total++; if (o_valid !== 1'b0) $display("FAIL redir_t1_valid got=%b exp=0", o_valid); else pass_cnt++;
    total++;
    if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h200)
      $display("FAIL redir_t1_req got=%b/%h exp=1/00000200", o_bus_req, o_bus_addr);
    else pass_cnt++;
    tick(1, 1, 0, '0);
    total++; if (o_valid !== 1'b0) $display("FAIL redir_t2_valid got=%b exp=0", o_valid); else pass_cnt++;
    tick(1, 1, 0, '0);
    total++;
    if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instr !== memf(32'h200))
      $display("FAIL redir_t3 got=%b/%h/%h exp=1/00000200/%h", o_valid, o_pc, o_instr, memf(32'h200));
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int          n = 0;
    logic [31:0] e;
    tick(1, 1, 1, 32'hFFFF_FFF9);
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (o_valid === 1'b1) begin
        e = 32'hFFFF_FFF8 + 32'(4 * n);
        total++;
        if (o_pc !== e || o_instr !== memf(e)) $display("FAIL wrap_pc n=%0d got=%h exp=%h", n, o_pc, e);
        else pass_cnt++;
        n++;
      end
      tick(1, 1, 0, '0);
    end
    total++; if (n != 4) $display("FAIL wrap_count got=%0d exp=4", n); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    tick(1, 1, 1, 32'h0000_0300);
    total++; if (o_valid !== 1'b0) $display("FAIL b2b_valid1 got=%b exp=0", o_valid); else pass_cnt++;
    tick(1, 1, 1, 32'h0000_0400);
    total++; if (o_valid !== 1'b0) $display("FAIL b2b_valid2 got=%b exp=0", o_valid); else pass_cnt++;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (o_valid === 1'b1) begin
        seen = 1;
        total++; if (o_pc !== 32'h400) $display("FAIL b2b_pc got=%h exp=00000400", o_pc); else pass_cnt++;
      end else tick(1, 1, 0, '0);
    end
    if (!seen) begin total++; $display("FAIL b2b_timeout got=no_valid exp=valid"); end
  endtask

  task automatic test_redirect_outst();
    bit ok = 0, seen = 0;
    lat_min = 4; lat_max = 4;
    for (int k = 0; k < 30 && !ok; k++) begin
      if (pend.size() == 2) ok = 1; else tick(1, 1, 0, '0);
    end
    total++; if (!ok) $display("FAIL outst_setup got=%0d exp=2", pend.size()); else pass_cnt++;
    tick(0, 1, 1, 32'h0000_0100);
    total++; if (o_valid !== 1'b0) $display("FAIL outst_valid_t1 got=%b exp=0", o_valid); else pass_cnt++;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (o_valid === 1'b1) begin
        seen = 1;
        total++;
        if (o_pc !== 32'h100 || o_instr !== memf(32'h100))
          $display("FAIL outst_first got=%h/%h exp=00000100/%h", o_pc, o_instr, memf(32'h100));
        else pass_cnt++;
      end else tick(1, 1, 0, '0);
    end
    if (!seen) begin total++; $display("FAIL outst_timeout got=no_valid exp=valid"); end
    lat_min = 1; lat_max = 5;
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, rpc, prev_addr;
    bit          gnt, rdy, redir, prev_wait = 0;
    int          consumed = 0;
    lat_min = 1; lat_max = 5;
    tick(1, 1, 1, 32'h0000_1000);
    exp_fetch = 32'h0000_1000;
    for (int k = 0; k < 1500; k++) begin
      gnt   = ($urandom % 10) < 7;
      rdy   = ($urandom % 10) < 6;
      redir = ($urandom % 40) == 0;
      rpc   = $urandom;
      total++;
      if (o_valid !== (exp_q.size() != 0)) $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, o_valid, exp_q.size() != 0);
      else pass_cnt++;
      total++;
      if (exp_q.size() != 0) begin
        if (o_pc !== exp_q[0] || o_instr !== memf(exp_q[0]))
          $display("FAIL rnd_head k=%0d got=%h/%h exp=%h/%h", k, o_pc, o_instr, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
      end else begin
        if (o_instr !== NOP) $display("FAIL rnd_nop k=%0d got=%h exp=%h", k, o_instr, NOP); else pass_cnt++;
      end
      total++;
      if (pend.size() > 2 || exp_q.size() > 4)
        $display("FAIL rnd_bounds k=%0d got=%0d/%0d exp=<=2/<=4", k, pend.size(), exp_q.size());
      else pass_cnt++;
      if (prev_wait) begin
        total++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== prev_addr)
          $display("FAIL rnd_stable k=%0d got=%b/%h exp=1/%h", k, o_bus_req, o_bus_addr, prev_addr);
        else pass_cnt++;
      end
      if (o_bus_req === 1'b1 && gnt) begin
        total++;
        if (o_bus_addr !== exp_fetch) $display("FAIL rnd_fetch k=%0d got=%h exp=%h", k, o_bus_addr, exp_fetch);
        else pass_cnt++;
        exp_fetch += 4;
      end
      if (redir) exp_fetch = {rpc[31:2], 2'b00};
      if (o_valid === 1'b1 && rdy && !redir) consumed++;
      prev_wait = (o_bus_req === 1'b1) && !gnt && !redir;
      prev_addr = o_bus_addr;
      tick(gnt, rdy, redir, rpc);
    end
    total++; if (consumed < 100) $display("FAIL rnd_progress got=%0d exp=>=100", consumed); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_fast();
    test_wrap();
    test_back_to_back();
    test_redirect_outst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch unit sitting directly upstream of the pipelined core's fetch stage, between the instruction-memory bus and the core's instruction input. Issues sequential word fetches ahead of the core, buffers returned instructions with their PCs in a small FIFO, and presents them to the fetch stage with a valid/ready handshake. On a taken branch or jump from the execute stage it flushes buffered and in-flight fetches and restarts at the redirect target.

## Interface
Parameters:
- `WIDTH`, 32, instruction/data word width
- `ADDR_W`, 32, fetch address width
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `MAX_OUTST`, 2, maximum granted-but-unanswered bus requests (1..DEPTH)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `i_clk` in 1: single clock, all logic rising-edge
- `i_rst` in 1: synchronous, active-high reset
- `o_bus_req` out 1: fetch request valid
- `o_bus_addr` out ADDR_W: word-aligned fetch address
- `i_bus_gnt` in 1: request accepted this cycle (handshake = `o_bus_req & i_bus_gnt`)
- `i_bus_rvalid` in 1: read data valid; responses return in request order, ≥ 1 cycle after grant
- `i_bus_rdata` in WIDTH: instruction word
- `o_valid` out 1: `o_instr`/`o_pc` hold a valid instruction
- `o_instr` out WIDTH: head instruction
- `o_pc` out ADDR_W: PC of head instruction
- `i_ready` in 1: core consumes head (driven as `~if_stall`)
- `i_redirect` in 1: execute-stage PC redirect (taken branch/jump)
- `i_redirect_pc` in ADDR_W: redirect target

## Operation
- Fetch pointer `fpc` holds the next address to request; advances by 4 (mod 2^ADDR_W) on each grant.
- Request issued when `count + outst < DEPTH` and `outst < MAX_OUTST`; `o_bus_addr` stable while `o_bus_req` is high and ungranted, except on redirect.
- Each grant pushes its address into an in-order PC tag queue (MAX_OUTST deep); each non-discarded response pushes `{tag_pc, rdata}` into the FIFO.
- Pop when `o_valid & i_ready`.
- Redirect: FIFO cleared, `fpc ← {i_redirect_pc[ADDR_W-1:2], 2'b00}`, any ungranted request withdrawn, `discard ← outst` (including a grant in the redirect cycle); the next `discard` responses are dropped without a FIFO push.
- Push and pop in the same cycle when full: allowed, count unchanged.
- Redirect concurrent with `i_bus_rvalid`: response dropped (counted against discard). Redirect concurrent with pop: pop ignored.
- Consecutive redirects: each recomputes `discard` from the current outstanding count; only the last target is fetched.

## Timing
- Reset values: `o_bus_req`=0, `o_bus_addr`=RESET_PC, `o_valid`=0, `o_instr`=32'h0000_0013 (NOP), `o_pc`=RESET_PC, count/outst/discard = 0.
- First `o_bus_req` in the first cycle after `i_rst` deasserts.
- All outputs registered. Response at cycle t appears on `o_valid` at t+1 (when the FIFO was empty).
- Minimum redirect-to-valid: redirect at t, request at t+1 (granted), rvalid t+2, `o_valid` t+3.
- `o_valid` drops the cycle after redirect; `o_instr` reverts to NOP when the FIFO is empty.
- Sustained throughput: 1 instruction/cycle with a 1-cycle bus and `i_ready` high.
- Reset mid-operation: all state cleared in one cycle; responses already in flight after reset are the bus's responsibility (the bus is reset by the same `i_rst`).

## Structure
- Shared package constants: `NOP_INSTR` (32'h0000_0013), `RESET_PC` default, `PC_INC` (4).
- One sub-module: `instr_fifo`, a synchronous FIFO of `{pc, instr}` with push, pop, clear, full, empty, and count. The PC tag queue reuses it with depth MAX_OUTST.

## Test plan
- Reset then 1-cycle bus, `i_ready`=1 → requests at 0x0, 0x4, 0x8…; `o_valid` from cycle 3, `o_pc` 0x0, 0x4, 0x8 on consecutive cycles.
- `i_ready`=0 for 10 cycles → exactly DEPTH=4 instructions buffered, `o_bus_req` low, and no lost or duplicated PC after release.
- Redirect to 0x100 while 2 requests are outstanding → both responses dropped; next `o_pc` = 0x100 at redirect+3; no stale instruction presented.
- Redirect in the same cycle as `i_bus_rvalid` and a grant → the response is dropped, the granted request is discarded, and the fetch restarts at target.
- Redirect to 0x103 → fetch at 0x100; fetch near 0xFFFF_FFFC wraps to 0x0000_0000.
- Random `i_bus_gnt` / latency 1–5 and random `i_ready` against a scoreboard → in-order PCs, `outst` ≤ MAX_OUTST, no FIFO overflow.
